// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the sequential ALU.
//   alu_op_e    - opcode encodings carried on alu_control
//   alu_state_e - control FSM states
//   FLAG_*      - bit positions inside the {N,Z,C,V} flag vector
package alu_pkg;

  localparam int ALU_CTRL_W = 4;

  typedef enum logic [ALU_CTRL_W-1:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_AND = 4'b0010,
    OP_ORR = 4'b0011,
    OP_EOR = 4'b0100,
    OP_ADC = 4'b0101,
    OP_SBC = 4'b0110,
    OP_RSB = 4'b0111,
    OP_MOV = 4'b1000,
    OP_MVN = 4'b1001,
    OP_BIC = 4'b1010,
    OP_MUL = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_iter_mul.sv
// alu_iter_mul: shift-add multiplier, one multiplier bit per cycle,
// truncated to WIDTH bits.
//   clk, rst_n  - clock, async active-low reset
//   start       - load operands a/b and begin (ignored while busy is irrelevant:
//                 the owner only pulses it when idle)
//   a, b        - multiplicand / multiplier
//   done        - high during the cycle in which the last bit is processed
//   product     - valid while done is high (value about to be accumulated)
module alu_iter_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_nxt;

  always_comb begin
    acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : '0);
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = a;
      mplier_d = b;
      cnt_d    = CNT_W'(WIDTH);
    end else if (cnt_q != '0) begin
      acc_d    = acc_nxt;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - 1'b1;
    end
  end

  // Product is handed out combinationally on the final step so the owner
  // can register it on the same edge the last bit is consumed.
  assign done    = (cnt_q == CNT_W'(1));
  assign product = acc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: registered, handshaked ALU with persistent NZCV flags.
//   clk, rst_n            - clock, async active-low reset
//   in_valid/in_ready     - operand handshake (ready only when idle)
//   a, b, alu_control     - operands and opcode (alu_pkg::alu_op_e)
//   set_flags             - commit NZCV when this op's result is taken
//   out_valid/out_ready   - result handshake
//   result                - registered result
//   flags_nzcv            - committed flags {N,Z,C,V}
//
// state | meaning
// IDLE  | waiting for an op, in_ready=1
// RUN   | iterative multiply in progress
// DONE  | result valid, waiting for out_ready; flags commit on the take
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = ALU_CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [CTRL_W-1:0] alu_control,
  input  logic              set_flags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic [3:0]        flags_nzcv
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic [3:0]       pend_q, pend_d;
  logic             pend_we_q, pend_we_d;

  alu_op_e          op;
  logic [WIDTH-1:0] add_x, add_y;
  logic             add_cin;
  logic [WIDTH:0]   add_sum;
  logic             is_arith;
  logic [WIDTH-1:0] core_res;
  logic             core_we;
  logic             core_c, core_v;
  logic [3:0]       core_flags;

  logic             mul_start, mul_done;
  logic [WIDTH-1:0] mul_product;

  alu_iter_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle core. Subtractions reuse the adder as x + ~y + cin, which
  // yields the ARM "C = NOT borrow" directly from the carry out.
  always_comb begin
    op       = alu_op_e'(alu_control);
    add_x    = a;
    add_y    = b;
    add_cin  = 1'b0;
    is_arith = 1'b0;
    core_res = '0;
    core_we  = 1'b1;
    case (op)
      OP_ADD: is_arith = 1'b1;
      OP_SUB: begin add_y = ~b; add_cin = 1'b1; is_arith = 1'b1; end
      OP_ADC: begin add_cin = flags_q[FLAG_C]; is_arith = 1'b1; end
      OP_SBC: begin add_y = ~b; add_cin = flags_q[FLAG_C]; is_arith = 1'b1; end
      OP_RSB: begin add_x = b; add_y = ~a; add_cin = 1'b1; is_arith = 1'b1; end
      OP_AND: core_res = a & b;
      OP_ORR: core_res = a | b;
      OP_EOR: core_res = a ^ b;
      OP_MOV: core_res = b;
      OP_MVN: core_res = ~b;
      OP_BIC: core_res = a & ~b;
      OP_MUL: core_res = '0;
      default: core_we = 1'b0;
    endcase
    add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
    core_c  = flags_q[FLAG_C];
    core_v  = flags_q[FLAG_V];
    if (is_arith) begin
      core_res = add_sum[WIDTH-1:0];
      core_c   = add_sum[WIDTH];
      core_v   = (add_x[WIDTH-1] == add_y[WIDTH-1]) &&
                 (add_sum[WIDTH-1] != add_x[WIDTH-1]);
    end
    core_flags = {core_res[WIDTH-1], core_res == '0, core_c, core_v};
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    flags_d   = flags_q;
    pend_d    = pend_q;
    pend_we_d = pend_we_q;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          pend_we_d = set_flags && core_we;
          if (op == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = ST_RUN;
          end else begin
            result_d = core_res;
            pend_d   = core_flags;
            state_d  = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (mul_done) begin
          result_d = mul_product;
          pend_d   = {mul_product[WIDTH-1], mul_product == '0,
                      flags_q[FLAG_C], flags_q[FLAG_V]};
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          if (pend_we_q) flags_d = pend_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      flags_q   <= '0;
      pend_q    <= '0;
      pend_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      pend_q    <= pend_d;
      pend_we_q <= pend_we_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign result     = result_q;
  assign flags_nzcv = flags_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
module tb_alu_seq_unit;

  localparam int W = 3;
  localparam int W32 = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic         in_valid = 0, in_ready, set_flags = 0, out_valid, out_ready = 0;
  logic [W-1:0] a = '0, b = '0, result;
  logic [3:0]   ctrl = '0, flags;

  logic          in_valid32 = 0, in_ready32, set_flags32 = 0, out_valid32, out_ready32 = 0;
  logic [W32-1:0] a32 = '0, b32 = '0, result32;
  logic [3:0]    ctrl32 = '0, flags32;

  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] mflags = 4'b0000;
  logic [3:0] mflags32 = 4'b0000;

  alu_seq_unit #(.WIDTH(W), .CTRL_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_control(ctrl), .set_flags(set_flags),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flags_nzcv(flags)
  );

  alu_seq_unit #(.WIDTH(W32), .CTRL_W(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .a(a32), .b(b32), .alu_control(ctrl32), .set_flags(set_flags32),
    .out_valid(out_valid32), .out_ready(out_ready32), .result(result32),
    .flags_nzcv(flags32)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain integer arithmetic on unsigned and signed views.
  function automatic void ref_op(input int w, input int op, input longint ua,
                                 input longint ub, input logic [3:0] fin,
                                 output longint res, output logic [3:0] fout,
                                 output bit we);
    longint m, half, sa, sb, full, sres;
    bit arith, c, v, brw;
    m = longint'(1) << w;
    half = m >> 1;
    sa = (ua >= half) ? ua - m : ua;
    sb = (ub >= half) ? ub - m : ub;
    arith = 0; c = fin[1]; v = fin[0]; we = 1; full = 0; sres = 0;
    brw = !fin[1];
    case (op)
      0:  begin full = ua + ub; sres = sa + sb; c = (full >= m); arith = 1; end
      1:  begin full = ua - ub; sres = sa - sb; c = (ua >= ub); arith = 1; end
      5:  begin full = ua + ub + longint'(fin[1]); sres = sa + sb + longint'(fin[1]);
                c = (full >= m); arith = 1; end
      6:  begin full = ua - ub - longint'(brw); sres = sa - sb - longint'(brw);
                c = (ua >= ub + longint'(brw)); arith = 1; end
      7:  begin full = ub - ua; sres = sb - sa; c = (ub >= ua); arith = 1; end
      2:  full = ua & ub;
      3:  full = ua | ub;
      4:  full = ua ^ ub;
      8:  full = ub;
      9:  full = ~ub;
      10: full = ua & ~ub;
      12: full = ua * ub;
      default: we = 0;
    endcase
    res = full & (m - 1);
    if (arith) v = (sres < -half) || (sres > half - 1);
    fout = {((res >> (w - 1)) & 1) != 0, res == 0, c, v};
    if (!we) res = 0;
  endfunction

  task automatic issue(input int op, input int av, input int bv, input bit s);
    ctrl = 4'(op); a = W'(av); b = W'(bv); set_flags = s; in_valid = 1;
    tick();
    in_valid = 0;
    a = W'($urandom); b = W'($urandom); ctrl = 4'($urandom); set_flags = 1'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 0;
    #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_cmp++; if (result !== 3'b000) begin n_err++; $display("FAIL reset_result got %b exp 000", result); end
    n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL reset_flags got %b exp 0000", flags); end
    tick(); tick();
    rst_n = 1;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    mflags = 0; mflags32 = 0;
  endtask

  task automatic test_directed();
    int d_op[5] = '{0, 0, 2, 1, 5};
    int d_a[5]  = '{1, 3, 5, 1, 1};
    int d_b[5]  = '{1, 1, 3, 1, 1};
    int d_s[5]  = '{1, 1, 1, 1, 0};
    int d_r[5]  = '{2, 4, 1, 0, 3};
    int d_f[5]  = '{0, 9, 1, 6, 6};
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL dir%0d_in_ready got %b exp 1", i, in_ready); end
      issue(d_op[i], d_a[i], d_b[i], 1'(d_s[i]));
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL dir%0d_out_valid got %b exp 1", i, out_valid); end
      n_cmp++; if (result !== 3'(d_r[i])) begin n_err++; $display("FAIL dir%0d_result got %b exp %b", i, result, 3'(d_r[i])); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL dir%0d_busy got %b exp 0", i, in_ready); end
      out_ready = 1; tick(); out_ready = 0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL dir%0d_taken got %b exp 0", i, out_valid); end
      n_cmp++; if (flags !== 4'(d_f[i])) begin n_err++; $display("FAIL dir%0d_flags got %b exp %b", i, flags, 4'(d_f[i])); end
    end
    mflags = 4'b0110;
  endtask

  task automatic test_stall();
    issue(3, 5, 1, 1);
    in_valid = 1; ctrl = 4'd0; a = 3'd1; b = 3'd1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || result !== 3'b101 || in_ready !== 1'b0) begin
        n_err++; $display("FAIL stall%0d got v=%b r=%b rdy=%b exp v=1 r=101 rdy=0", i, out_valid, result, in_ready);
      end
      tick();
    end
    in_valid = 0; out_ready = 1; tick(); out_ready = 0;
    n_cmp++; if (flags !== 4'b1010) begin n_err++; $display("FAIL stall_flags got %b exp 1010", flags); end
    tick();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL stall_no_queue got v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
    end
    mflags = 4'b1010;
  endtask

  task automatic test_mul();
    int lat;
    issue(12, 3, 3, 1);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mul_busy got %b exp 0", in_ready); end
      tick(); lat++;
    end
    n_cmp++; if (lat != W + 1) begin n_err++; $display("FAIL mul_latency got %0d exp %0d", lat, W + 1); end
    n_cmp++; if (result !== 3'b001) begin n_err++; $display("FAIL mul_result got %b exp 001", result); end
    out_ready = 1; tick(); out_ready = 0;
    n_cmp++; if (flags !== 4'b0010) begin n_err++; $display("FAIL mul_flags got %b exp 0010", flags); end
    mflags = 4'b0010;
  endtask

  task automatic test_random();
    longint er; logic [3:0] ef; bit we; int op, av, bv, lat, stall; bit s;
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 15); av = $urandom_range(0, 7); bv = $urandom_range(0, 7); s = 1'($urandom);
      ref_op(W, op, longint'(av), longint'(bv), mflags, er, ef, we);
      issue(op, av, bv, s);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
      n_cmp++; if (lat != ((op == 12) ? W : 0)) begin n_err++; $display("FAIL rand%0d_latency op=%0d got %0d", i, op, lat); end
      n_cmp++; if (result !== 3'(er)) begin n_err++; $display("FAIL rand%0d_result op=%0d a=%0d b=%0d got %b exp %b", i, op, av, bv, result, 3'(er)); end
      stall = $urandom_range(0, 2);
      for (int k = 0; k < stall; k++) begin
        tick();
        n_cmp++; if (out_valid !== 1'b1 || result !== 3'(er)) begin n_err++; $display("FAIL rand%0d_hold got v=%b r=%b", i, out_valid, result); end
      end
      out_ready = 1; tick(); out_ready = 0;
      if (s && we) mflags = ef;
      n_cmp++; if (flags !== mflags) begin n_err++; $display("FAIL rand%0d_flags op=%0d s=%0d got %b exp %b", i, op, s, flags, mflags); end
    end
  endtask

  task automatic test_reset_mid_mul();
    issue(12, 3, 3, 1);
    tick();
    rst_n = 0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || flags !== 4'b0000) begin
      n_err++; $display("FAIL rst_mid_mul got v=%b f=%b exp v=0 f=0000", out_valid, flags);
    end
    tick();
    rst_n = 1;
    mflags = 0; mflags32 = 0;
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready got %b exp 1", in_ready); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (out_valid !== 1'b0 || result !== 3'b000) begin
        n_err++; $display("FAIL rst_stale%0d got v=%b r=%b exp v=0 r=000", i, out_valid, result);
      end
      tick();
    end
  endtask

  task automatic test_smoke32();
    longint er; logic [3:0] ef; bit we; int op, lat; bit s; logic [31:0] av, bv;
    int ops[6] = '{0, 1, 12, 6, 9, 13};
    for (int i = 0; i < 12; i++) begin
      op = ops[$urandom_range(0, 5)]; av = $urandom; bv = $urandom; s = 1'($urandom);
      if (i == 0) begin av = 32'h7fff_ffff; bv = 32'h1; op = 0; s = 1; end
      ref_op(W32, op, longint'(av), longint'(bv), mflags32, er, ef, we);
      ctrl32 = 4'(op); a32 = av; b32 = bv; set_flags32 = s; in_valid32 = 1;
      tick();
      in_valid32 = 0;
      lat = 0;
      while (out_valid32 !== 1'b1 && lat < 60) begin tick(); lat++; end
      n_cmp++; if (lat != ((op == 12) ? W32 : 0)) begin n_err++; $display("FAIL w32_%0d_latency got %0d", i, lat); end
      n_cmp++; if (result32 !== 32'(er)) begin n_err++; $display("FAIL w32_%0d_result op=%0d got %h exp %h", i, op, result32, 32'(er)); end
      out_ready32 = 1; tick(); out_ready32 = 0;
      if (s && we) mflags32 = ef;
      n_cmp++; if (flags32 !== mflags32) begin n_err++; $display("FAIL w32_%0d_flags got %b exp %b", i, flags32, mflags32); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_mul();
    test_random();
    test_reset_mid_mul();
    test_smoke32();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
